// File: rtl/sps_rx_framer.sv
// Receive-side frame controller for the SPS serial link: qualifies a start bit at 16x, runs
// the external bit counter, assembles an LSB-first byte and hands it off on a valid/ack pair.
module sps_rx_framer #(
  parameter int unsigned FRAME_WIDTH = 10,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned START_QUAL  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  bit_clk,
  input  logic                  endFrame,
  output logic                  enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ack,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int unsigned IdxW  = $clog2(FRAME_WIDTH);
  localparam int unsigned QualW = $clog2(START_QUAL + 1);

  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(FRAME_WIDTH - 1);
  localparam logic [QualW-1:0] QualLast = QualW'(START_QUAL - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStartQ,
    StRecv,
    StDone,
    StWaitHi
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic                  bclk_q;
  logic                  bit_tick;
  logic [QualW-1:0]      qual_q, qual_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      bclk_q    <= 1'b0;
    end else begin
      rx_meta_q <= serial_in;
      rx_s_q    <= rx_meta_q;
      bclk_q    <= bit_clk;
    end
  end

  assign bit_tick = bit_clk & ~bclk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      qual_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      qual_q     <= qual_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    qual_d     = qual_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    ferr_d     = 1'b0;

    // Consumer side; a DONE cycle below overrides these.
    if (data_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        qual_d = '0;
        idx_d  = '0;
        if (!rx_s_q) begin
          state_d = StStartQ;
          qual_d  = QualW'(1);
        end
      end

      StStartQ: begin
        if (rx_s_q) begin
          state_d = StIdle;
          qual_d  = '0;
        end else if (qual_q == QualLast) begin
          state_d = StRecv;
          qual_d  = '0;
          idx_d   = '0;
        end else begin
          qual_d = qual_q + QualW'(1);
        end
      end

      StRecv: begin
        if (bit_tick) begin
          idx_d = idx_q + IdxW'(1);
          if (idx_q == '0) begin
            if (rx_s_q) begin
              ferr_d  = 1'b1;
              state_d = StWaitHi;
              idx_d   = '0;
            end
          end else if (idx_q == LastIdx) begin
            idx_d = '0;
            if (rx_s_q) begin
              state_d = StDone;
            end else begin
              ferr_d  = 1'b1;
              state_d = StWaitHi;
            end
          end else begin
            shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          end
        end else if (endFrame && (idx_q < LastIdx)) begin
          // Counter finished before we saw every bit: the frame cannot be trusted.
          ferr_d  = 1'b1;
          state_d = StWaitHi;
          idx_d   = '0;
        end
      end

      StDone: begin
        state_d    = StIdle;
        data_out_d = shift_q;
        valid_d    = 1'b1;
        ovr_d      = data_ack ? 1'b0 : (valid_q | ovr_q);
      end

      StWaitHi: begin
        shift_d = '0;
        idx_d   = '0;
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign enable     = (state_q == StRecv);
  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_sps_rx_framer.sv
// Directed bench for sps_rx_framer with a behavioural bit counter and a byte scoreboard.
module tb_sps_rx_framer;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       bit_clk;
  logic       endFrame;
  logic       enable;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       frame_err;
  logic       overrun;
  logic       ef_force;

  logic [3:0] cnt_q;
  logic [3:0] nbits_q;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  int   cyc         = 0;
  int   en_cycles   = 0;
  int   fe_cnt      = 0;
  int   fe_run      = 0;
  int   fe_len      = 0;
  int   en_fall_cyc = 0;
  int   dv_rise_cyc = 0;
  logic en_prev     = 1'b0;
  logic dv_prev     = 1'b0;
  logic fe_prev     = 1'b0;

  sps_rx_framer #(
    .FRAME_WIDTH(10),
    .DATA_WIDTH (8),
    .START_QUAL (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .bit_clk   (bit_clk),
    .endFrame  (endFrame),
    .enable    (enable),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ack  (data_ack),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit counter: bit_clk rises every 16 clk while enabled; endFrame after 10 rises.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      nbits_q <= 4'd0;
      bit_clk <= 1'b0;
    end else if (!enable) begin
      cnt_q   <= 4'd0;
      nbits_q <= 4'd0;
      bit_clk <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 4'd1;
      bit_clk <= (cnt_q < 4'd8);
      if (cnt_q == 4'd0 && nbits_q != 4'd10) nbits_q <= nbits_q + 4'd1;
    end
  end

  assign endFrame = (enable && nbits_q == 4'd10) || ef_force;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (enable) en_cycles <= en_cycles + 1;
    if (en_prev && !enable) en_fall_cyc <= cyc;
    if (!dv_prev && data_valid) dv_rise_cyc <= cyc;
    if (frame_err && !fe_prev) fe_cnt <= fe_cnt + 1;
    if (frame_err) fe_run <= fe_run + 1;
    else if (fe_prev) begin
      fe_len <= fe_run;
      fe_run <= 0;
    end
    en_prev <= enable;
    dv_prev <= data_valid;
    fe_prev <= frame_err;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      serial_in = 1'b1;
    end
  endtask

  // Drives one 10-bit frame at 16 clk/bit; optional early endFrame, mid-frame reset,
  // or data_ack in the DONE cycle (the first cycle enable reads low again).
  task automatic send_frame(input logic [7:0] data, input logic stop, input bit good,
                            input int ef_bit, input int rst_bit, input bit ack_done);
    logic [9:0] bits;
    logic       prev_en;
    bits    = {stop, data, 1'b0};
    prev_en = 1'b0;
    if (good) exp_q.push_back(data);
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        serial_in = bits[b];
        ef_force  = (b == ef_bit) && (i == 4);
        data_ack  = ack_done && prev_en && !enable;
        prev_en   = enable;
        if (b == rst_bit && i == 6) begin
          ef_force = 1'b0;
          data_ack = 1'b0;
          chk("rst_pre_running", enable, 1);
          #3 rst = 1'b0;
          #1;
          chk("rst_enable", enable, 0);
          chk("rst_data_out", data_out, 0);
          chk("rst_data_valid", data_valid, 0);
          chk("rst_overrun", overrun, 0);
          chk("rst_frame_err", frame_err, 0);
          @(negedge clk);
          rst       = 1'b1;
          serial_in = 1'b1;
          return;
        end
      end
    end
    ef_force = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic check_rx(input logic exp_ovr, input bit chk_lat);
    logic [7:0] e;
    e = 8'h00;
    chk("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk("data_out", data_out, e);
    chk("data_valid", data_valid, 1);
    chk("overrun", overrun, exp_ovr);
    chk("enable_low", enable, 0);
    if (chk_lat) chk("valid_latency", dv_rise_cyc - en_fall_cyc, 1);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  initial begin
    int en_snap;
    int fe_snap;
    rst       = 1'b0;
    serial_in = 1'b1;
    data_ack  = 1'b0;
    ef_force  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_enable", enable, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_data_valid", data_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b1;
    idle(20);

    // Clean frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1, 1'b0);
    check_rx(1'b0, 1'b1);
    chk("a5_no_frame_err", fe_cnt, 0);
    idle(10);
    ack_pulse();
    chk("ack_clears_valid", data_valid, 0);
    chk("ack_keeps_data", data_out, 8'hA5);
    ack_pulse();
    chk("idle_ack_valid", data_valid, 0);
    chk("idle_ack_overrun", overrun, 0);

    // Three-clk glitch must be rejected.
    en_snap = en_cycles;
    fe_snap = fe_cnt;
    repeat (3) begin
      @(negedge clk);
      serial_in = 1'b0;
    end
    idle(30);
    chk("glitch_no_enable", en_cycles, en_snap);
    chk("glitch_no_err", fe_cnt, fe_snap);
    chk("glitch_valid", data_valid, 0);
    chk("glitch_data", data_out, 8'hA5);

    // Bad stop bit, line held low: one-clk error, no restart until the line goes high.
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 1'b0);
    en_snap = en_cycles;
    repeat (24) begin
      @(negedge clk);
      serial_in = 1'b0;
    end
    chk("stop_err_count", fe_cnt, 1);
    chk("stop_err_width", fe_len, 1);
    chk("stop_err_valid", data_valid, 0);
    chk("stop_err_data", data_out, 8'hA5);
    chk("stop_err_hold_low", en_cycles, en_snap);
    idle(30);

    // endFrame arriving mid-frame aborts with an error.
    send_frame(8'hFF, 1'b1, 1'b0, 2, -1, 1'b0);
    idle(20);
    chk("early_ef_count", fe_cnt, 2);
    chk("early_ef_width", fe_len, 1);
    chk("early_ef_valid", data_valid, 0);
    chk("early_ef_enable", enable, 0);

    // Overrun: 0x11 then 0x22 with no ack.
    send_frame(8'h11, 1'b1, 1'b1, -1, -1, 1'b0);
    check_rx(1'b0, 1'b1);
    idle(10);
    send_frame(8'h22, 1'b1, 1'b1, -1, -1, 1'b0);
    check_rx(1'b1, 1'b0);
    idle(5);
    ack_pulse();
    chk("ovr_ack_valid", data_valid, 0);
    chk("ovr_ack_overrun", overrun, 0);
    idle(10);

    // Ack landing in the DONE cycle while 0x66 is pending.
    send_frame(8'h66, 1'b1, 1'b1, -1, -1, 1'b0);
    check_rx(1'b0, 1'b1);
    idle(10);
    send_frame(8'h77, 1'b1, 1'b1, -1, -1, 1'b1);
    check_rx(1'b0, 1'b0);
    idle(10);

    // Reset at data bit 4, then a clean 0x5A.
    send_frame(8'h96, 1'b1, 1'b0, -1, 5, 1'b0);
    idle(30);
    chk("post_rst_valid", data_valid, 0);
    send_frame(8'h5A, 1'b1, 1'b1, -1, -1, 1'b0);
    check_rx(1'b0, 1'b1);
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
